banco_registradores: RTL

32 × 32-bit MIPS register file with a registered operand-fetch stage, sitting directly upstream of the ALU. Each read request registers rs/rt operands and a 32-bit extended immediate, which the ALU consumes as `valor1`, `valor2` and `imediato` on the following edge. The write-back path writes results, typically the ALU's `aluresult` after the memory stage. Same-cycle write/read collisions resolve write-first, so the ALU never sees a stale operand.

---
 rtl/banco_registradores_pkg.sv | 20 ++
 rtl/banco_registradores_extensor_sinal.sv | 17 +
 rtl/banco_registradores.sv | 75 +++++++
 3 files changed

// File: rtl/banco_registradores_pkg.sv
// Shared constants and operand payload type for the register file and the control unit.
package banco_registradores_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned IMM_W    = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam logic EXT_SIGN = 1'b0;
    localparam logic EXT_ZERO = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] valor1;
        logic [DATA_W-1:0] valor2;
        logic [DATA_W-1:0] imediato;
    } operandos_t;

endpackage

// File: rtl/banco_registradores_extensor_sinal.sv
// Combinational 16->32 immediate extender; also reused for branch-offset generation.
module extensor_sinal
    import banco_registradores_pkg::*;
(
    input  logic [IMM_W-1:0]  imm16,
    input  logic              ext_sel,
    output logic [DATA_W-1:0] imediato_c
);

    always_comb begin
        imediato_c = {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};
        if (ext_sel == EXT_ZERO) begin
            imediato_c = {{(DATA_W-IMM_W){1'b0}}, imm16};
        end
    end

endmodule

// File: rtl/banco_registradores.sv
// 32x32 MIPS register file with a registered operand-fetch stage feeding the ALU.
module banco_registradores
    import banco_registradores_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [IMM_W-1:0]  imm16,
    input  logic              ext_sel,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] valor1,
    output logic [DATA_W-1:0] valor2,
    output logic [DATA_W-1:0] imediato,
    output logic              op_valid
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] leitura1_c;
    logic [DATA_W-1:0] leitura2_c;
    logic [DATA_W-1:0] imediato_c;
    logic              escrita_c;
    operandos_t        ops_q;

    assign escrita_c = regwrite && (wr_addr != REG_ZERO);

    extensor_sinal u_extensor (
        .imm16      (imm16),
        .ext_sel    (ext_sel),
        .imediato_c (imediato_c)
    );

    // Write-first read ports: a same-cycle write to the addressed register is bypassed.
    always_comb begin
        leitura1_c = '0;
        leitura2_c = '0;
        if (rs != REG_ZERO) begin
            leitura1_c = (escrita_c && (wr_addr == rs)) ? wr_data : regs[rs];
        end
        if (rt != REG_ZERO) begin
            leitura2_c = (escrita_c && (wr_addr == rt)) ? wr_data : regs[rt];
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '{default: '0};
        end else if (escrita_c) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q    <= '0;
            op_valid <= 1'b0;
        end else begin
            op_valid <= rd_en;
            if (rd_en) begin
                ops_q.valor1   <= leitura1_c;
                ops_q.valor2   <= leitura2_c;
                ops_q.imediato <= imediato_c;
            end
        end
    end

    assign valor1   = ops_q.valor1;
    assign valor2   = ops_q.valor2;
    assign imediato = ops_q.imediato;

endmodule
